// File: rtl/rf_pulse_gate.sv
// Transmit pulse shaper: gates a phase-cycled, amplitude-scaled DDS stream for the DAC.
// One start runs a pre-delay, an RF pulse and a 3-cycle pipeline drain; tx_gate tracks dac_out.
module rf_pulse_gate #(
  parameter int LANES = 8,
  parameter int W     = 16,
  parameter int CW    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LANES*W-1:0]   dds_i,
  input  logic [LANES*W-1:0]   dds_q,
  input  logic                 dds_valid,
  input  logic                 start,
  input  logic [CW-1:0]        delay_len,
  input  logic [CW-1:0]        pulse_len,
  input  logic [15:0]          amp,
  input  logic [1:0]           phase,
  output logic [LANES*W-1:0]   dac_out,
  output logic                 dac_valid,
  output logic                 tx_gate,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int PW = W + 17;
  localparam logic [CW-1:0] ZERO_C      = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DRAIN_LEN_C = {{(CW-2){1'b0}}, 2'b11};
  localparam logic [15:0]   AMP_MAX_C   = 16'h8000;
  localparam logic signed [PW:0] RND_C  = {{(PW-14){1'b0}}, 1'b1, 14'b0};
  localparam logic signed [PW:0] MAX_C  = {{(PW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW:0] MIN_C  = {{(PW-W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [CW-1:0]     pulse_len_r;
  logic [15:0]       amp_r;
  logic [1:0]        phase_r;
  logic              gate_s, load_s, abort_s, finish_s;
  logic              g1_r, g2_r, v1_r, v2_r;
  logic signed [W-1:0]  s1_r [LANES];
  logic signed [PW-1:0] s2_r [LANES];

  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] x);
    if (x == {1'b1, {(W-1){1'b0}}}) begin
      neg_sat = {1'b0, {(W-1){1'b1}}};
    end else begin
      neg_sat = -x;
    end
  endfunction

  // Real part of (I + jQ) rotated by the selected quarter turn
  function automatic logic signed [W-1:0] phase_sel(input logic signed [W-1:0] i_v,
                                                    input logic signed [W-1:0] q_v,
                                                    input logic [1:0] ph);
    case (ph)
      2'd0:    phase_sel = i_v;
      2'd1:    phase_sel = neg_sat(q_v);
      2'd2:    phase_sel = neg_sat(i_v);
      2'd3:    phase_sel = q_v;
      default: phase_sel = i_v;
    endcase
  endfunction

  function automatic logic signed [W-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW:0] r;
    logic signed [PW:0] sh;
    r  = {p[PW-1], p} + RND_C;
    sh = r >>> 15;
    if (sh > MAX_C) begin
      round_sat = MAX_C[W-1:0];
    end else if (sh < MIN_C) begin
      round_sat = MIN_C[W-1:0];
    end else begin
      round_sat = sh[W-1:0];
    end
  endfunction

  // Next-state logic; the counter is reloaded on every state entry and counts down to 1
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    gate_s   = 1'b0;
    load_s   = 1'b0;
    abort_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && dds_valid) begin
          load_s = 1'b1;
          if (delay_len != ZERO_C) begin
            state_s = DELAY;
            cnt_s   = delay_len;
          end else if (pulse_len != ZERO_C) begin
            state_s = PULSE;
            cnt_s   = pulse_len;
          end else begin
            state_s = DRAIN;
            cnt_s   = DRAIN_LEN_C;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DELAY: begin
        if (!dds_valid) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else if (cnt_r != ONE_C) begin
          cnt_s = cnt_r - ONE_C;
        end else if (pulse_len_r != ZERO_C) begin
          state_s = PULSE;
          cnt_s   = pulse_len_r;
        end else begin
          state_s = DRAIN;
          cnt_s   = DRAIN_LEN_C;
        end
      end
      PULSE: begin
        if (!dds_valid) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else begin
          gate_s = 1'b1;
          if (cnt_r != ONE_C) begin
            cnt_s = cnt_r - ONE_C;
          end else begin
            state_s = DRAIN;
            cnt_s   = DRAIN_LEN_C;
          end
        end
      end
      DRAIN: begin
        if (cnt_r != ONE_C) begin
          cnt_s = cnt_r - ONE_C;
        end else begin
          state_s  = IDLE;
          finish_s = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Control registers, latched parameters and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= ZERO_C;
      pulse_len_r <= ZERO_C;
      amp_r       <= 16'h0000;
      phase_r     <= 2'd0;
      err         <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (load_s) begin
        pulse_len_r <= pulse_len;
        amp_r       <= (amp > AMP_MAX_C) ? AMP_MAX_C : amp;
        phase_r     <= phase;
      end
      if (load_s) begin
        err <= 1'b0;
      end else if (abort_s) begin
        err <= 1'b1;
      end
      done <= finish_s;
      busy <= (state_s != IDLE);
    end
  end

  // Three-stage datapath: phase select, scale, round/saturate/gate; gate and valid ride alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        s1_r[l] <= {W{1'b0}};
        s2_r[l] <= {PW{1'b0}};
      end
      dac_out   <= {(LANES*W){1'b0}};
      g1_r      <= 1'b0;
      g2_r      <= 1'b0;
      tx_gate   <= 1'b0;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      dac_valid <= 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        s1_r[l] <= phase_sel(dds_i[l*W +: W], dds_q[l*W +: W], phase_r);
        s2_r[l] <= PW'(s1_r[l]) * PW'($signed({1'b0, amp_r}));
        dac_out[l*W +: W] <= g2_r ? round_sat(s2_r[l]) : {W{1'b0}};
      end
      g1_r      <= gate_s;
      g2_r      <= g1_r;
      tx_gate   <= g2_r;
      v1_r      <= dds_valid;
      v2_r      <= v1_r;
      dac_valid <= v2_r;
    end
  end

endmodule

// File: tb/tb_rf_pulse_gate.sv
// Self-checking bench for rf_pulse_gate: constant table, directed multi-cycle sequences and
// randomized traffic, all checked every cycle against a cycle-number-based reference model.
module tb_rf_pulse_gate;
  localparam int LANES = 8;
  localparam int W     = 16;
  localparam int CW    = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [LANES*W-1:0]   dds_i, dds_q, dac_out;
  logic                 dds_valid, start;
  logic [CW-1:0]        delay_len, pulse_len;
  logic [15:0]          amp;
  logic [1:0]           phase;
  logic                 dac_valid, tx_gate, busy, done, err;

  rf_pulse_gate #(.LANES(LANES), .W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .dds_i(dds_i), .dds_q(dds_q), .dds_valid(dds_valid),
    .start(start), .delay_len(delay_len), .pulse_len(pulse_len), .amp(amp), .phase(phase),
    .dac_out(dac_out), .dac_valid(dac_valid), .tx_gate(tx_gate), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  // Reference model: one sequence described by its start cycle and lengths
  bit     m_active, m_aborted, m_err;
  longint m_t0, m_d, m_p, m_abort_c;
  int     m_amp, m_phase;
  typedef struct { bit g; bit v; logic [LANES*W-1:0] data; } pq_t;
  pq_t    pipe[$];

  typedef struct { int i; int q; logic [15:0] a; logic [1:0] ph; int exp; } vec_t;
  vec_t   tbl[11];

  function automatic int ref_sample(int i_v, int q_v, int ph, int a);
    int v;
    longint p;
    longint r;
    case (ph)
      0:       v = i_v;
      1:       v = -q_v;
      2:       v = -i_v;
      default: v = q_v;
    endcase
    if (v > 32767) v = 32767;
    if (a > 32768) a = 32768;
    p = longint'(v) * longint'(a);
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  function automatic bit m_busy(longint c);
    return m_active && c >= m_t0 + 1 && c <= m_t0 + m_d + m_p + 3 && !(m_aborted && c > m_abort_c);
  endfunction

  function automatic bit m_done(longint c);
    return m_active && !m_aborted && c == m_t0 + m_d + m_p + 4;
  endfunction

  task automatic model_reset();
    pq_t z;
    z.g = 1'b0; z.v = 1'b0; z.data = '0;
    m_active = 1'b0; m_aborted = 1'b0; m_err = 1'b0;
    pipe.delete();
    repeat (3) pipe.push_back(z);
  endtask

  task automatic chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    pq_t e;
    bit  b, d;
    e = pipe[0];
    b = m_busy(cyc);
    d = m_done(cyc);
    n_vec++;
    if (dac_out !== e.data || dac_valid !== e.v || tx_gate !== e.g || busy !== b ||
        done !== d || err !== m_err) begin
      n_bad++;
      $display("FAIL cycle %0d: got dac_out=%h valid=%b gate=%b busy=%b done=%b err=%b, expected %h %b %b %b %b %b",
               cyc, dac_out, dac_valid, tx_gate, busy, done, err, e.data, e.v, e.g, b, d, m_err);
    end
  endtask

  // Advance the model by the inputs of cycle cyc, then pass the clock edge and check cycle cyc+1
  task automatic model_update();
    pq_t e;
    bit  b;
    b = m_busy(cyc);
    if (b && cyc <= m_t0 + m_d + m_p && !dds_valid) begin
      m_aborted = 1'b1;
      m_abort_c = cyc;
      m_err     = 1'b1;
    end
    e.g = b && dds_valid && cyc >= m_t0 + m_d + 1 && cyc <= m_t0 + m_d + m_p;
    e.v = dds_valid;
    e.data = '0;
    if (e.g) begin
      for (int l = 0; l < LANES; l++)
        e.data[l*W +: W] = 16'(ref_sample(int'($signed(dds_i[l*W +: W])),
                                          int'($signed(dds_q[l*W +: W])), m_phase, m_amp));
    end
    if (!b && start && dds_valid) begin
      m_active = 1'b1; m_aborted = 1'b0; m_t0 = cyc;
      m_d = longint'(delay_len); m_p = longint'(pulse_len);
      m_amp = int'(amp); m_phase = int'(phase); m_err = 1'b0;
    end
    void'(pipe.pop_front());
    pipe.push_back(e);
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic set_lanes(int i_v, int q_v);
    for (int l = 0; l < LANES; l++) begin
      dds_i[l*W +: W] = 16'(i_v);
      dds_q[l*W +: W] = 16'(q_v);
    end
  endtask

  task automatic run_seq(input int d, input int p, input logic [15:0] a, input logic [1:0] ph,
                         input int drop_rel, input bit poke,
                         output int first_gate, output int n_gate, output int done_rel,
                         output int busy_n, output int lane_val, output int err_after);
    first_gate = -1; n_gate = 0; done_rel = -1; busy_n = 0; lane_val = 0;
    dds_valid = 1'b1; start = 1'b1;
    delay_len = CW'(d); pulse_len = CW'(p); amp = a; phase = ph;
    step();
    start = 1'b0;
    for (int k = 1; k <= d + p + 8; k++) begin
      if (tx_gate) begin
        n_gate++;
        if (first_gate < 0) first_gate = k;
        lane_val = int'($signed(dac_out[W-1:0]));
      end
      if (done) done_rel = k;
      if (busy) busy_n++;
      dds_valid = (k == drop_rel) ? 1'b0 : 1'b1;
      start = poke && (k == 3);
      if (start) begin delay_len = '0; pulse_len = CW'(1); amp = 16'h1000; phase = 2'd1; end
      step();
    end
    start = 1'b0;
    err_after = int'(err);
  endtask

  int fg, ng, dr, bn, lv, ea;

  initial begin
    tbl[0]  = '{1000, -2000, 16'h8000, 2'd0, 1000};
    tbl[1]  = '{1000, -2000, 16'h8000, 2'd1, 2000};
    tbl[2]  = '{1000, -2000, 16'h8000, 2'd2, -1000};
    tbl[3]  = '{1000, -2000, 16'h8000, 2'd3, -2000};
    tbl[4]  = '{3, 0, 16'h4000, 2'd0, 2};
    tbl[5]  = '{-32768, 0, 16'hFFFF, 2'd2, 32767};
    tbl[6]  = '{0, -32768, 16'h8000, 2'd1, 32767};
    tbl[7]  = '{-32768, 0, 16'h8000, 2'd0, -32768};
    tbl[8]  = '{32767, 5, 16'h8000, 2'd0, 32767};
    tbl[9]  = '{-3, 0, 16'h4000, 2'd0, -1};
    tbl[10] = '{12345, 0, 16'h2000, 2'd0, 3086};

    rst_n = 1'b0; start = 1'b0; dds_valid = 1'b0;
    delay_len = '0; pulse_len = '0; amp = '0; phase = '0;
    set_lanes(0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Table: one short pulse per vector, lane value during tx_gate against the constant
    foreach (tbl[v]) begin
      set_lanes(tbl[v].i, tbl[v].q);
      run_seq(1, 2, tbl[v].a, tbl[v].ph, 0, 1'b0, fg, ng, dr, bn, lv, ea);
      chk($sformatf("table%0d_value", v), lv, tbl[v].exp);
      chk($sformatf("table%0d_gate_len", v), ng, 2);
    end

    // D=2, P=5 basic timing
    set_lanes(1000, 0);
    run_seq(2, 5, 16'h8000, 2'd0, 0, 1'b0, fg, ng, dr, bn, lv, ea);
    chk("basic_first_gate", fg, 6);
    chk("basic_gate_len", ng, 5);
    chk("basic_done_cycle", dr, 11);
    chk("basic_busy_len", bn, 10);
    chk("basic_value", lv, 1000);

    // D=0, P=0
    run_seq(0, 0, 16'h8000, 2'd0, 0, 1'b0, fg, ng, dr, bn, lv, ea);
    chk("zero_gate_len", ng, 0);
    chk("zero_done_cycle", dr, 4);
    chk("zero_busy_len", bn, 3);

    // Abort on the third PULSE cycle
    run_seq(1, 5, 16'h8000, 2'd0, 4, 1'b0, fg, ng, dr, bn, lv, ea);
    chk("abort_gate_len", ng, 2);
    chk("abort_first_gate", fg, 5);
    chk("abort_no_done", dr, -1);
    chk("abort_busy_len", bn, 4);
    chk("abort_err", ea, 1);

    // Next start clears err; a start while busy must not disturb timing
    run_seq(2, 5, 16'h8000, 2'd0, 0, 1'b1, fg, ng, dr, bn, lv, ea);
    chk("poke_first_gate", fg, 6);
    chk("poke_gate_len", ng, 5);
    chk("poke_done_cycle", dr, 11);
    chk("err_cleared", ea, 0);

    // Asynchronous reset mid-pulse
    dds_valid = 1'b1; start = 1'b1; delay_len = '0; pulse_len = CW'(20);
    amp = 16'h8000; phase = 2'd0; set_lanes(-1234, 0);
    step();
    start = 1'b0;
    repeat (6) step();
    chk("pre_reset_gate", int'(tx_gate), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs_zero", {dac_out != '0, dac_valid, tx_gate, busy, done, err}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int l = 0; l < LANES; l++) begin
        dds_i[l*W +: W] = 16'($urandom);
        dds_q[l*W +: W] = 16'($urandom);
      end
      dds_valid = ($urandom_range(0, 39) != 0);
      start     = ($urandom_range(0, 5) == 0);
      delay_len = CW'($urandom_range(0, 5));
      pulse_len = CW'($urandom_range(0, 7));
      amp       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 32768));
      phase     = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
